// File: rtl/comp_inv_if.sv
// ----------------------------------------------------------------------------
// comp_inv_if - start/done handshake bundle for the cubic-term inverter.
//   start  : request pulse from the requester
//   y      : q22.8 cubic term to invert (sampled with an accepted start)
//   busy   : conversion in progress (held through the done cycle)
//   done   : one-cycle result-valid pulse
//   x      : recovered q7.0 angle, held until the next done
//   exact  : 43*x^3 == y for the delivered x, held with x
// master = requester side, slave = comp_inv side.
// ----------------------------------------------------------------------------
interface comp_inv_if #(
  parameter int XW = 7,
  parameter int YW = 30
);
  logic          start;
  logic [YW-1:0] y;
  logic          busy;
  logic          done;
  logic [XW-1:0] x;
  logic          exact;

  modport master (output start, y, input busy, done, x, exact);
  modport slave  (input start, y, output busy, done, x, exact);
endinterface

// File: rtl/comp_inv.sv
// ----------------------------------------------------------------------------
// comp_inv - inverse of the cubic-term generator.
// Recovers x = floor value such that 43*x^3 <= y from a q22.8 term y, using an
// MSB-first successive-approximation search. Each bit takes three cycles:
// square the trial, cube it, then scale by K and compare against the captured y.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (aborts any conversion in flight)
//   bus : comp_inv_if.slave (start, y, busy, done, x, exact)
// ----------------------------------------------------------------------------
module comp_inv #(
  parameter int          XW = 7,
  parameter int          YW = 30,
  parameter logic [5:0]  K  = 6'd43
) (
  input  logic       clk,
  input  logic       rst,
  comp_inv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    CUBE = 2'd2,
    CMP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [YW-1:0]   r_yr;
  logic [XW-1:0]   r_acc;
  logic [XW-1:0]   r_trial;
  logic [2:0]      r_i;
  logic [2*XW-1:0] r_sq;
  logic [3*XW-1:0] r_cube;
  logic            r_eq;
  logic [XW-1:0]   r_x;
  logic            r_exact;
  logic            r_done;
  logic            r_busy;

  logic [YW-1:0]   w_f;
  logic            w_keep;
  logic [XW-1:0]   w_acc_new;
  logic            w_eq_new;

  // K*cube as a constant shift-add; with K=43 the terms are <<5, <<3, <<1, <<0.
  always_comb begin
    w_f = '0;
    for (int b = 0; b < 6; b++) begin
      if (K[b]) begin
        w_f = w_f + (YW'(r_cube) << b);
      end else begin
        w_f = w_f;
      end
    end
  end

  // Compare decision for the current trial and the running exact-hit flag.
  // Once a kept trial hits y exactly, every later (larger) trial is rejected,
  // so the retained flag is the final answer.
  always_comb begin
    w_keep    = (w_f <= r_yr);
    w_acc_new = w_keep ? r_trial : r_acc;
    w_eq_new  = r_eq | (w_keep & (w_f == r_yr));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next = SQ;
        end else begin
          w_next = IDLE;
        end
      end
      SQ:   w_next = CUBE;
      CUBE: w_next = CMP;
      CMP: begin
        if (r_i != 3'd0) begin
          w_next = SQ;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_yr    <= '0;
      r_acc   <= '0;
      r_trial <= '0;
      r_i     <= 3'd0;
      r_sq    <= '0;
      r_cube  <= '0;
      r_eq    <= 1'b0;
      r_x     <= '0;
      r_exact <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // busy also covers the done cycle; a start on that edge keeps it high.
          r_busy <= bus.start;
          if (bus.start) begin
            r_yr    <= bus.y;
            r_acc   <= '0;
            r_i     <= 3'(XW - 1);
            r_trial <= XW'(1) << (XW - 1);
            // x=0 is exact only for y=0; no trial can ever detect that case.
            r_eq    <= (bus.y == '0);
          end
        end
        SQ: begin
          r_sq <= r_trial * r_trial;
        end
        CUBE: begin
          r_cube <= r_sq * (2*XW)'(r_trial);
        end
        CMP: begin
          r_acc <= w_acc_new;
          r_eq  <= w_eq_new;
          if (r_i != 3'd0) begin
            r_i     <= r_i - 3'd1;
            r_trial <= w_acc_new | (XW'(1) << (r_i - 3'd1));
          end else begin
            r_x     <= w_acc_new;
            r_exact <= w_eq_new;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.x     = r_x;
  assign bus.exact = r_exact;

endmodule
